// File: rtl/alu_pkg.sv
// Shared types for the ALU datapath and its requester arbiter.
package alu_pkg;

    typedef enum logic [1:0] {
        ALU_ADD = 2'b00,
        ALU_SUB = 2'b01,
        ALU_AND = 2'b10,
        ALU_OR  = 2'b11
    } alu_f_t;

    localparam int FLAG_Z = 0;
    localparam int FLAG_V = 1;
    localparam int FLAG_N = 2;
    localparam int FLAG_C = 3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_EXEC = 2'b01,
        ST_RESP = 2'b10
    } arb_state_t;

endpackage

// File: rtl/alu32.sv
// 32-bit ALU: ADD/SUB/AND/OR with {C,N,V,Z} flags; purely combinational.
module alu32
    import alu_pkg::*;
(
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    input  logic [1:0]  f_i,
    output logic [31:0] y_o,
    output logic [3:0]  flags_o
);

    logic [32:0] sum;
    logic [31:0] y;
    logic        c;
    logic        v;

    // SUB carry is the inverted borrow (A + ~B + 1), so A>=B gives C=1.
    always_comb begin
        sum = '0;
        y   = '0;
        c   = 1'b0;
        v   = 1'b0;
        case (alu_f_t'(f_i))
            ALU_ADD: begin
                sum = {1'b0, a_i} + {1'b0, b_i};
                y   = sum[31:0];
                c   = sum[32];
                v   = (a_i[31] == b_i[31]) && (y[31] != a_i[31]);
            end
            ALU_SUB: begin
                sum = {1'b0, a_i} + {1'b0, ~b_i} + 33'd1;
                y   = sum[31:0];
                c   = sum[32];
                v   = (a_i[31] != b_i[31]) && (y[31] != a_i[31]);
            end
            ALU_AND: y = a_i & b_i;
            ALU_OR:  y = a_i | b_i;
            default: y = '0;
        endcase
    end

    always_comb begin
        flags_o         = '0;
        flags_o[FLAG_C] = c;
        flags_o[FLAG_N] = y[31];
        flags_o[FLAG_V] = v;
        flags_o[FLAG_Z] = (y == 32'd0);
        y_o             = y;
    end

endmodule

// File: rtl/rr_arbiter.sv
// Round-robin grant: searches from last+1 upward, wrapping modulo NREQ.
module rr_arbiter #(
    parameter int NREQ = 2,
    parameter int IDW  = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req_i,
    input  logic [IDW-1:0]  last_i,
    output logic [NREQ-1:0] gnt_o,
    output logic [IDW-1:0]  gnt_id_o
);

    logic [IDW-1:0] idx;
    logic           found;

    always_comb begin
        gnt_o    = '0;
        gnt_id_o = '0;
        found    = 1'b0;
        idx      = '0;
        for (int k = 1; k <= NREQ; k++) begin
            idx = IDW'((int'(last_i) + k) % NREQ);
            if (!found && req_i[idx]) begin
                found      = 1'b1;
                gnt_o[idx] = 1'b1;
                gnt_id_o   = idx;
            end
        end
    end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one alu32 between NREQ requesters with round-robin grant and a tagged response.
// Optional ALU_ARB_STICKY_OVF_EN adds per-requester sticky overflow bits with a sync clear.
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int NREQ = 2,
    parameter int IDW  = $clog2(NREQ)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [NREQ*32-1:0]   req_a,
    input  logic [NREQ*32-1:0]   req_b,
    input  logic [NREQ*2-1:0]    req_f,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [IDW-1:0]       rsp_id,
    output logic [31:0]          rsp_y,
    output logic [3:0]           rsp_flags
`ifdef ALU_ARB_STICKY_OVF_EN
    ,
    input  logic                 clr_sticky,
    output logic [NREQ-1:0]      sticky_ovf
`endif
);

    arb_state_t     state_q, state_d;
    logic [IDW-1:0] last_q, last_d;
    logic [IDW-1:0] id_q, id_d;
    logic [31:0]    a_q, a_d, b_q, b_d, y_q, y_d;
    logic [1:0]     f_q, f_d;
    logic [3:0]     flags_q, flags_d;

    logic [31:0]     a_arr [NREQ];
    logic [31:0]     b_arr [NREQ];
    logic [1:0]      f_arr [NREQ];
    logic [NREQ-1:0] gnt;
    logic [IDW-1:0]  gnt_id;
    logic [31:0]     alu_y;
    logic [3:0]      alu_flags;

    for (genvar i = 0; i < NREQ; i++) begin : g_unpack
        assign a_arr[i] = req_a[32*i +: 32];
        assign b_arr[i] = req_b[32*i +: 32];
        assign f_arr[i] = req_f[2*i +: 2];
    end

    rr_arbiter #(.NREQ(NREQ), .IDW(IDW)) u_rr (
        .req_i    (req_valid),
        .last_i   (last_q),
        .gnt_o    (gnt),
        .gnt_id_o (gnt_id)
    );

    alu32 u_alu (
        .a_i     (a_q),
        .b_i     (b_q),
        .f_i     (f_q),
        .y_o     (alu_y),
        .flags_o (alu_flags)
    );

    always_comb begin
        state_d   = state_q;
        last_d    = last_q;
        id_d      = id_q;
        a_d       = a_q;
        b_d       = b_q;
        f_d       = f_q;
        y_d       = y_q;
        flags_d   = flags_q;
        req_ready = '0;
        case (state_q)
            ST_IDLE: begin
                req_ready = gnt;
                if (|(req_valid & gnt)) begin
                    a_d     = a_arr[gnt_id];
                    b_d     = b_arr[gnt_id];
                    f_d     = f_arr[gnt_id];
                    id_d    = gnt_id;
                    last_d  = gnt_id;
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                y_d     = alu_y;
                flags_d = alu_flags;
                state_d = ST_RESP;
            end
            ST_RESP: begin
                if (rsp_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            last_q  <= IDW'(NREQ - 1);
            id_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            f_q     <= '0;
            y_q     <= '0;
            flags_q <= '0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            id_q    <= id_d;
            a_q     <= a_d;
            b_q     <= b_d;
            f_q     <= f_d;
            y_q     <= y_d;
            flags_q <= flags_d;
        end
    end

    assign rsp_valid = (state_q == ST_RESP);
    assign rsp_id    = id_q;
    assign rsp_y     = y_q;
    assign rsp_flags = flags_q;

`ifdef ALU_ARB_STICKY_OVF_EN
    logic [NREQ-1:0] sticky_q, sticky_d;

    // Clear is applied last so it overrides a same-cycle set.
    always_comb begin
        sticky_d = sticky_q;
        if (rsp_valid && rsp_ready && flags_q[FLAG_V]) sticky_d[id_q] = 1'b1;
        if (clr_sticky) sticky_d = '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sticky_q <= '0;
        else        sticky_q <= sticky_d;
    end

    assign sticky_ovf = sticky_q;
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter (NREQ=2); inputs driven and outputs sampled on the falling edge.
module tb_alu_arbiter;

    localparam int NREQ = 2;
    localparam int IDW  = 1;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [NREQ-1:0]   req_valid;
    logic [NREQ-1:0]   req_ready;
    logic [NREQ*32-1:0] req_a;
    logic [NREQ*32-1:0] req_b;
    logic [NREQ*2-1:0] req_f;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [IDW-1:0]    rsp_id;
    logic [31:0]       rsp_y;
    logic [3:0]        rsp_flags;
`ifdef ALU_ARB_STICKY_OVF_EN
    logic              clr_sticky;
    logic [NREQ-1:0]   sticky_ovf;
`endif

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    alu_arbiter #(.NREQ(NREQ), .IDW(IDW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_f     (req_f),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_y     (rsp_y),
        .rsp_flags (rsp_flags)
`ifdef ALU_ARB_STICKY_OVF_EN
        ,
        .clr_sticky (clr_sticky),
        .sticky_ovf (sticky_ovf)
`endif
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog expired at cyc=%0d", cyc);
        $fatal(1, "watchdog");
    end

    task automatic set_req(input int i, input logic [31:0] a, input logic [31:0] b, input logic [1:0] f);
        req_a[32*i +: 32] = a;
        req_b[32*i +: 32] = b;
        req_f[2*i +: 2]   = f;
    endtask

    task automatic wait_rsp(output bit seen);
        int k;
        k = 0;
        seen = 1'b0;
        while (!seen && k < 10) begin
            @(negedge clk);
            k++;
            if (rsp_valid === 1'b1) seen = 1'b1;
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0; req_valid = '0; rsp_ready = 1'b0;
        req_a = '0; req_b = '0; req_f = '0;
`ifdef ALU_ARB_STICKY_OVF_EN
        clr_sticky = 1'b0;
`endif
        repeat (2) @(negedge clk);
        total++; if (req_ready !== 2'b00) begin bad++; $display("FAIL reset_req_ready got=%b want=00", req_ready); end
        total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL reset_rsp_valid got=%b want=0", rsp_valid); end
        total++; if (rsp_y !== 32'h0) begin bad++; $display("FAIL reset_rsp_y got=%h want=0", rsp_y); end
        total++; if (rsp_flags !== 4'h0) begin bad++; $display("FAIL reset_rsp_flags got=%b want=0000", rsp_flags); end
        total++; if (rsp_id !== 1'b0) begin bad++; $display("FAIL reset_rsp_id got=%0d want=0", rsp_id); end
        rst_n = 1'b1;
    endtask

    task automatic test_single;
        @(negedge clk);
        set_req(0, 32'h7FFF_FFFF, 32'h1, 2'b00);
        req_valid = 2'b01;
        #1;
        total++; if (req_ready !== 2'b01) begin bad++; $display("FAIL single_grant got=%b want=01", req_ready); end
        @(posedge clk);
        @(negedge clk);
        req_valid = 2'b00;
        total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL single_exec_valid got=%b want=0", rsp_valid); end
        @(negedge clk);
        total++; if (rsp_valid !== 1'b1) begin bad++; $display("FAIL single_latency got=%b want=1", rsp_valid); end
        total++; if (rsp_y !== 32'h8000_0000) begin bad++; $display("FAIL single_y got=%h want=80000000", rsp_y); end
        total++; if (rsp_flags !== 4'b0110) begin bad++; $display("FAIL single_flags got=%b want=0110", rsp_flags); end
        total++; if (rsp_id !== 1'b0) begin bad++; $display("FAIL single_id got=%0d want=0", rsp_id); end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL single_done got=%b want=0", rsp_valid); end
    endtask

    task automatic test_alternate;
        logic [31:0] exp_y [2];
        logic [3:0]  exp_fl [2];
        int          prev;
        bit          seen;
        exp_y[0] = 32'h0;  exp_fl[0] = 4'b1001;
        exp_y[1] = 32'hFF; exp_fl[1] = 4'b0000;
        prev = 0;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        set_req(0, 32'd5, 32'd5, 2'b01);
        set_req(1, 32'hF0, 32'h0F, 2'b11);
        req_valid = 2'b11;
        rsp_ready = 1'b1;
        for (int n = 0; n < 4; n++) begin
            wait_rsp(seen);
            total++;
            if (!seen) begin
                bad++; $display("FAIL alt_timeout op=%0d got=none want=rsp", n);
            end else begin
                if (rsp_id !== 1'(n % 2) || rsp_y !== exp_y[n%2] || rsp_flags !== exp_fl[n%2]) begin
                    bad++;
                    $display("FAIL alt_rsp op=%0d got id=%0d y=%h fl=%b want id=%0d y=%h fl=%b",
                             n, rsp_id, rsp_y, rsp_flags, n % 2, exp_y[n%2], exp_fl[n%2]);
                end
                if (n > 0) begin
                    total++;
                    if (cyc - prev != 3) begin bad++; $display("FAIL alt_gap op=%0d got=%0d want=3", n, cyc - prev); end
                end
                prev = cyc;
            end
        end
        req_valid = 2'b00;
        @(negedge clk);
        rsp_ready = 1'b0;
    endtask

    task automatic test_backpressure;
        bit seen;
        @(negedge clk);
        set_req(0, 32'hFFFF_0000, 32'h8000_FFFF, 2'b10);
        set_req(1, 32'h1, 32'h1, 2'b00);
        req_valid = 2'b01;
        @(posedge clk);
        @(negedge clk);
        req_valid = 2'b11;
        wait_rsp(seen);
        total++;
        if (!seen || rsp_y !== 32'h8000_0000 || rsp_flags !== 4'b0100 || rsp_id !== 1'b0) begin
            bad++; $display("FAIL bp_rsp got v=%b y=%h fl=%b id=%0d want v=1 y=80000000 fl=0100 id=0",
                            seen, rsp_y, rsp_flags, rsp_id);
        end
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            total++;
            if (rsp_valid !== 1'b1 || rsp_y !== 32'h8000_0000 || rsp_flags !== 4'b0100 ||
                rsp_id !== 1'b0 || req_ready !== 2'b00) begin
                bad++; $display("FAIL bp_hold c=%0d got v=%b y=%h fl=%b id=%0d rdy=%b want v=1 y=80000000 fl=0100 id=0 rdy=00",
                                c, rsp_valid, rsp_y, rsp_flags, rsp_id, req_ready);
            end
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL bp_release got=%b want=0", rsp_valid); end
        total++; if (req_ready !== 2'b10) begin bad++; $display("FAIL bp_idle_grant got=%b want=10", req_ready); end
        req_valid = 2'b00;
        rsp_ready = 1'b0;
    endtask

    task automatic test_reset_exec;
        bit seen;
        @(negedge clk);
        set_req(0, 32'd5, 32'd5, 2'b01);
        req_valid = 2'b01;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        req_valid = 2'b00;
        #1;
        total++; if (rsp_y !== 32'h0) begin bad++; $display("FAIL rexec_y got=%h want=0", rsp_y); end
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL rexec_valid c=%0d got=%b want=0", c, rsp_valid); end
        end
        rst_n = 1'b1;
        set_req(1, 32'hF0, 32'h0F, 2'b11);
        req_valid = 2'b11;
        #1;
        total++; if (req_ready !== 2'b01) begin bad++; $display("FAIL rexec_first_grant got=%b want=01", req_ready); end
        @(posedge clk);
        @(negedge clk);
        req_valid = 2'b00;
        wait_rsp(seen);
        total++;
        if (!seen || rsp_id !== 1'b0 || rsp_y !== 32'h0 || rsp_flags !== 4'b1001) begin
            bad++; $display("FAIL rexec_rsp got v=%b id=%0d y=%h fl=%b want v=1 id=0 y=0 fl=1001",
                            seen, rsp_id, rsp_y, rsp_flags);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
    endtask

    task automatic test_withdraw;
        bit seen;
        @(negedge clk);
        set_req(0, 32'h8000_0000, 32'h8000_0000, 2'b00);
        set_req(1, 32'h3, 32'h4, 2'b00);
        req_valid = 2'b11;
        #1;
        total++; if (req_ready !== 2'b10) begin bad++; $display("FAIL wd_pre_grant got=%b want=10", req_ready); end
        #1;
        req_valid = 2'b01;
        #1;
        total++; if (req_ready !== 2'b01) begin bad++; $display("FAIL wd_regrant got=%b want=01", req_ready); end
        @(posedge clk);
        @(negedge clk);
        req_valid = 2'b00;
        wait_rsp(seen);
        total++;
        if (!seen || rsp_id !== 1'b0 || rsp_y !== 32'h0 || rsp_flags !== 4'b1011) begin
            bad++; $display("FAIL wd_rsp got v=%b id=%0d y=%h fl=%b want v=1 id=0 y=0 fl=1011",
                            seen, rsp_id, rsp_y, rsp_flags);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL wd_spurious c=%0d got v=%b id=%0d want v=0", c, rsp_valid, rsp_id); end
        end
    endtask

`ifdef ALU_ARB_STICKY_OVF_EN
    task automatic test_sticky;
        bit seen;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        set_req(1, 32'h7FFF_FFFF, 32'h1, 2'b00);
        req_valid = 2'b10;
        @(posedge clk);
        @(negedge clk);
        req_valid = 2'b00;
        wait_rsp(seen);
        total++;
        if (!seen || sticky_ovf !== 2'b00 || rsp_id !== 1'b1) begin
            bad++; $display("FAIL sticky_pre got v=%b st=%b id=%0d want v=1 st=00 id=1", seen, sticky_ovf, rsp_id);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        total++; if (sticky_ovf !== 2'b10) begin bad++; $display("FAIL sticky_set got=%b want=10", sticky_ovf); end
        clr_sticky = 1'b1;
        @(negedge clk);
        clr_sticky = 1'b0;
        total++; if (sticky_ovf !== 2'b00) begin bad++; $display("FAIL sticky_clr got=%b want=00", sticky_ovf); end
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_alternate();
        test_backpressure();
        test_reset_exec();
        test_withdraw();
`ifdef ALU_ARB_STICKY_OVF_EN
        test_sticky();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
